if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 21 ++
 rtl/if_stage_if.sv | 26 ++
 rtl/if_id_reg.sv | 62 ++++++
 rtl/if_stage.sv | 127 ++++++++++++
 tb/tb_if_stage.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: fetch FSM states
// and the default reset PC / bubble instruction values.
package if_stage_pkg;

  // Fetch FSM states.
  //   FETCH : request outstanding at PCF
  //   HOLD  : fetched word parked in the skid buffer, no request
  //   DRAIN : outstanding fetch is stale (redirected), awaiting its ack
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // addi x0,x0,0 -- the word ID sees when IF/ID is a bubble.
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  // PC loaded into PCF while reset is asserted.
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/acknowledge bus.
// Handshake: the fetch side raises imem_req with imem_addr and keeps
// imem_addr stable until a cycle where imem_ack=1; imem_rdata is valid only
// in that cycle. imem_ack may be high in the same cycle as imem_req, so one
// word per cycle is possible. The fetch side may drop imem_req (reset) with
// a request outstanding; the memory side must tolerate that.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: flush > stall > load > bubble.
// A flush always leaves a bubble; a stall freezes the contents.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic [31:0] pcd,
  output logic [31:0] instr,
  output logic        valid
);

  logic [31:0] pcd_q, pcd_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  // Next IF/ID contents from the flush/stall/load/bubble controls.
  always_comb begin
    pcd_d   = pcd_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (stall) begin
      // hold everything
    end else if (load) begin
      pcd_d   = pc_in;
      instr_d = instr_in;
      valid_d = 1'b1;
    end else if (bubble) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  // IF/ID state, asynchronously cleared to a bubble at PC 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcd_q   <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pcd_q   <= pcd_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pcd   = pcd_q;
  assign instr = instr_q;
  assign valid = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch FSM, PCF, pending-redirect target and a
// one-word skid buffer, feeding the IF/ID register. PCF only ever loads
// PC_In or the latched redirect target; next-PC arithmetic lives upstream.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       PC_In,
  input  logic              Redirect,
  input  logic              StallD,
  input  logic              FlushD,
  if_stage_if.master        imem,
  output logic [31:0]       PCF,
  output logic [31:0]       PCD,
  output logic [31:0]       InstrD,
  output logic              ValidD,
  output logic              FetchBusy,
  output fetch_state_e      state_dbg
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pcf_q, pcf_d;
  logic [31:0]  redir_pc_q, redir_pc_d;
  logic [31:0]  skid_q, skid_d;

  logic         id_load;
  logic         id_bubble;
  logic [31:0]  id_instr;

  // Fetch FSM: decides PCF/redirect/skid updates and what IF/ID receives.
  // Redirect outranks StallD for PCF and state; StallD only freezes IF/ID.
  always_comb begin
    state_d    = state_q;
    pcf_d      = pcf_q;
    redir_pc_d = redir_pc_q;
    skid_d     = skid_q;
    id_load    = 1'b0;
    id_instr   = imem.imem_rdata;
    unique case (state_q)
      FETCH: begin
        if (imem.imem_ack) begin
          if (Redirect) begin
            // word belongs to the wrong path: drop it
            pcf_d = PC_In;
          end else if (StallD) begin
            // ID cannot accept: park the word
            skid_d  = imem.imem_rdata;
            state_d = HOLD;
          end else begin
            id_load = 1'b1;
            pcf_d   = PC_In;
          end
        end else if (Redirect) begin
          // request must complete at the old address; remember the target
          redir_pc_d = PC_In;
          state_d    = DRAIN;
        end
      end
      HOLD: begin
        if (Redirect) begin
          pcf_d   = PC_In;
          state_d = FETCH;
        end else if (!StallD) begin
          id_load  = 1'b1;
          id_instr = skid_q;
          pcf_d    = PC_In;
          state_d  = FETCH;
        end
      end
      DRAIN: begin
        if (imem.imem_ack) begin
          // stale word discarded; a same-cycle redirect is the newest target
          pcf_d   = Redirect ? PC_In : redir_pc_q;
          state_d = FETCH;
        end else if (Redirect) begin
          redir_pc_d = PC_In;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // When ID is free and nothing real arrives, it gets a bubble.
  assign id_bubble = !id_load;

  // Fetch-side state; reset abandons any outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      pcf_q      <= RESET_PC;
      redir_pc_q <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      pcf_q      <= pcf_d;
      redir_pc_q <= redir_pc_d;
      skid_q     <= skid_d;
    end
  end

  assign imem.imem_req  = (state_q != HOLD);
  assign imem.imem_addr = pcf_q;
  assign FetchBusy      = (state_q != HOLD) && !imem.imem_ack;
  assign PCF            = pcf_q;
  assign state_dbg      = state_q;

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .stall    (StallD),
    .flush    (FlushD),
    .load     (id_load),
    .bubble   (id_bubble),
    .pc_in    (pcf_q),
    .instr_in (id_instr),
    .pcd      (PCD),
    .instr    (InstrD),
    .valid    (ValidD)
  );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by random traffic, all
// checked against a transaction-level fetch model.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [31:0]  PC_In;
  logic         Redirect, StallD, FlushD;
  logic [31:0]  PCF, PCD, InstrD;
  logic         ValidD, FetchBusy;
  fetch_state_e state_dbg;

  if_stage_if bus();

  if_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk       (clk),
    .rst       (rst),
    .PC_In     (PC_In),
    .Redirect  (Redirect),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .imem      (bus),
    .PCF       (PCF),
    .PCD       (PCD),
    .InstrD    (InstrD),
    .ValidD    (ValidD),
    .FetchBusy (FetchBusy),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0001;
  endfunction

  // What the pipeline front-end should look like, in transaction terms:
  // the fetch address, whether a word is waiting for ID, whether the
  // outstanding request is already known to be wrong-path and where
  // fetching should resume, plus the ID slot contents.
  logic [31:0] m_pcf, m_pcd, m_instr, m_park_word, m_target;
  logic        m_valid, m_parked, m_stale;

  task automatic model_reset();
    m_pcf = RST_PC; m_pcd = '0; m_instr = NOP; m_valid = 1'b0;
    m_parked = 1'b0; m_park_word = '0; m_stale = 1'b0; m_target = '0;
  endtask

  task automatic model_step(input bit ack, input logic [31:0] rd, input bit redir,
                            input logic [31:0] pcin, input bit stall, input bit flush);
    bit          delivered;
    logic [31:0] d_word, d_pc;
    delivered = 1'b0; d_word = '0; d_pc = m_pcf;
    if (m_parked) begin
      if (redir) begin
        m_parked = 1'b0; m_pcf = pcin;
      end else if (!stall) begin
        delivered = 1'b1; d_word = m_park_word; m_parked = 1'b0; m_pcf = pcin;
      end
    end else if (m_stale) begin
      if (ack) begin
        m_stale = 1'b0; m_pcf = redir ? pcin : m_target;
      end else if (redir) begin
        m_target = pcin;
      end
    end else if (ack) begin
      if (redir) m_pcf = pcin;
      else if (stall) begin m_parked = 1'b1; m_park_word = rd; end
      else begin delivered = 1'b1; d_word = rd; m_pcf = pcin; end
    end else if (redir) begin
      m_stale = 1'b1; m_target = pcin;
    end
    if (flush) begin
      m_valid = 1'b0; m_instr = NOP;
    end else if (!stall) begin
      if (delivered) begin m_pcd = d_pc; m_instr = d_word; m_valid = 1'b1; end
      else begin m_valid = 1'b0; m_instr = NOP; end
    end
  endtask

  function automatic fetch_state_e exp_state();
    if (m_parked) return HOLD;
    if (m_stale)  return DRAIN;
    return FETCH;
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1: drive one cycle of inputs, check the combinational
  // memory-side outputs, clock, then check the registered state.
  task automatic cycle(input bit ack, input bit redir, input logic [31:0] pcin,
                       input bit stall, input bit flush);
    logic [31:0] rd;
    rd = ack ? mem_word(m_pcf) : $urandom();
    bus.imem_ack = ack; bus.imem_rdata = rd;
    Redirect = redir; PC_In = pcin; StallD = stall; FlushD = flush;
    #1;
    chk("imem_req", 32'(bus.imem_req), 32'(!m_parked));
    if (!m_parked) chk("imem_addr", bus.imem_addr, m_pcf);
    chk("FetchBusy", 32'(FetchBusy), 32'(!m_parked && !ack));
    model_step(ack, rd, redir, pcin, stall, flush);
    @(posedge clk); #1;
    chk("PCF", PCF, m_pcf);
    chk("PCD", PCD, m_pcd);
    chk("InstrD", InstrD, m_instr);
    chk("ValidD", 32'(ValidD), 32'(m_valid));
    chk("state", 32'(state_dbg), 32'(exp_state()));
  endtask

  task automatic fwd(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, m_pcf + 32'd4, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    PC_In = '0; Redirect = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    model_reset();

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_PCF", PCF, RST_PC);
    chk("rst_PCD", PCD, 32'h0);
    chk("rst_InstrD", InstrD, NOP);
    chk("rst_ValidD", 32'(ValidD), 32'h0);
    chk("rst_state", 32'(state_dbg), 32'(FETCH));
    rst = 1'b0;

    // zero-wait streaming from reset: PCD 0,4,8,C
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, m_pcf + 32'd4, 1'b0, 1'b0);
      chk("stream_pcd", PCD, 32'(4 * i));
      chk("stream_valid", 32'(ValidD), 32'h1);
    end

    // two wait states at 0x10
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, m_pcf + 32'd4, 1'b0, 1'b0);
      chk("wait_bubble", 32'(ValidD), 32'h0);
    end
    cycle(1'b1, 1'b0, m_pcf + 32'd4, 1'b0, 1'b0);
    chk("wait_pcd", PCD, 32'h10);
    chk("wait_instr", InstrD, mem_word(32'h10));

    // stall on ack of 0x20
    fwd(3);
    cycle(1'b1, 1'b0, 32'h24, 1'b1, 1'b0);
    chk("stall_state", 32'(state_dbg), 32'(HOLD));
    chk("stall_pcd", PCD, 32'h1C);
    cycle(1'b0, 1'b0, 32'h24, 1'b1, 1'b0);
    chk("stall_req", 32'(bus.imem_req), 32'h0);
    cycle(1'b0, 1'b0, 32'h24, 1'b0, 1'b0);
    chk("unstall_pcd", PCD, 32'h20);
    chk("unstall_pcf", PCF, 32'h24);

    // redirects while 0x30 is pending; newest wins
    fwd(3);
    cycle(1'b0, 1'b0, 32'h34, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
    chk("drain_state", 32'(state_dbg), 32'(DRAIN));
    cycle(1'b0, 1'b1, 32'h200, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h34, 1'b0, 1'b0);
    chk("redir_discard", 32'(ValidD), 32'h0);
    chk("redir_addr", bus.imem_addr, 32'h200);

    // flush + stall + ack together
    cycle(1'b1, 1'b0, 32'h204, 1'b1, 1'b1);
    chk("flush_valid", 32'(ValidD), 32'h0);
    chk("flush_instr", InstrD, 32'h0000_0013);
    cycle(1'b0, 1'b0, 32'h204, 1'b0, 1'b0);
    chk("flush_release_pcd", PCD, 32'h200);

    // 32-bit wrap of the PC
    cycle(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0);
    fwd(3);
    chk("wrap_pcf", PCF, 32'h4);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit a, r, s, f;
      logic [31:0] tgt;
      a   = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 7) == 0);
      s   = ($urandom_range(0, 4) == 0);
      f   = ($urandom_range(0, 9) == 0);
      tgt = r ? (32'($urandom_range(0, 4095)) << 2) : (m_pcf + 32'd4);
      cycle(a, r, tgt, s, f);
    end

    // reset asserted while draining a stale fetch
    cycle(1'b0, 1'b0, m_pcf + 32'd4, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h400, 1'b0, 1'b0);
    if (state_dbg != DRAIN) cycle(1'b0, 1'b1, 32'h400, 1'b0, 1'b0);
    chk("pre_rst_state", 32'(state_dbg), 32'(DRAIN));
    #2;
    rst = 1'b1;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("async_rst_pcf", PCF, RST_PC);
    chk("async_rst_state", 32'(state_dbg), 32'(FETCH));
    chk("async_rst_valid", 32'(ValidD), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("post_rst_pcf", PCF, RST_PC);
    cycle(1'b0, 1'b0, RST_PC + 32'd4, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, RST_PC + 32'd4, 1'b0, 1'b0);
    chk("post_rst_pcd", PCD, RST_PC);
    chk("post_rst_instr", InstrD, mem_word(RST_PC));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
